// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle core: opcodes, controller states and
// the select/function codes understood by the ALU decoder and datapath.
package mc_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC    = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWR   = 4'd4;
    localparam logic [3:0] S_ALUWB   = 4'd5;
    localparam logic [3:0] S_MEMWB   = 4'd6;
    localparam logic [3:0] S_BRANCH  = 4'd7;
    localparam logic [3:0] S_LMSM    = 4'd8;
    localparam logic [3:0] S_HALTERR = 4'd9;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_NAND  = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_CMP   = 3'b011;
    localparam logic [2:0] ALU_ADDNF = 3'b100;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_IMM6 = 2'b01;
    localparam logic [1:0] PC_IMM9 = 2'b10;
    localparam logic [1:0] PC_RB   = 2'b11;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_LHI = 2'b10;
    localparam logic [1:0] WD_PC1 = 2'b11;

    localparam logic [1:0] AD_PC   = 2'b00;
    localparam logic [1:0] AD_ALU  = 2'b01;
    localparam logic [1:0] AD_LMSM = 2'b10;

    localparam logic [1:0] BS_RB   = 2'b00;
    localparam logic [1:0] BS_IMM6 = 2'b01;
    localparam logic [1:0] BS_ONE  = 2'b10;

    // ALU function for an opcode, used both in EXEC and held through writeback.
    function automatic logic [2:0] alu_f_for(input logic [3:0] op);
        case (op)
            OP_NDU:               return ALU_NAND;
            OP_LHI, OP_LW, OP_SW: return ALU_ADDNF;
            OP_BEQ:               return ALU_CMP;
            default:              return ALU_ADD;
        endcase
    endfunction

    function automatic logic [1:0] b_src_for(input logic [3:0] op);
        case (op)
            OP_ADI, OP_LW, OP_SW: return BS_IMM6;
            default:              return BS_RB;
        endcase
    endfunction

endpackage

// File: rtl/mc_lmsm_seq.sv
// LM/SM mask scanner: walks mask bits 1..7, counting completed transfers
// in lmsm_off; clear bits are skipped one per cycle.
module mc_lmsm_seq
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       active,
    input  logic [7:0] mask,
    input  logic       mem_ready,
    output logic [2:0] index,
    output logic [2:0] lmsm_off,
    output logic       bit_set,
    output logic       xfer,
    output logic       done
);

    logic step;

    assign bit_set = mask[index];
    assign xfer    = active & bit_set & mem_ready;
    assign step    = active & (~bit_set | mem_ready);
    assign done    = step & (index == 3'd7);

    // Index starts at 1: bit 0 would address R0, which is the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index    <= 3'd1;
            lmsm_off <= '0;
        end else if (start) begin
            index    <= 3'd1;
            lmsm_off <= '0;
        end else if (step) begin
            index <= index + 3'd1;
            if (xfer) begin
                lmsm_off <= lmsm_off + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// and LM/SM transfers, driving register-file, PC/IR and memory controls.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic        mem_ready,
    input  logic        alu_eq,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  addr_src,
    output logic [2:0]  lmsm_off,
    output logic [2:0]  ra1,
    output logic [2:0]  ra2,
    output logic [2:0]  wa3,
    output logic        reg_we,
    output logic [1:0]  wd_src,
    output logic [2:0]  alu_f,
    output logic [1:0]  alu_b_src,
    output logic        busy
);

    if (ADDR_W != 16) begin : g_addr_w_chk
        $error("mc_ctrl_fsm: ADDR_W must match the 16-bit datapath word");
    end

    logic [3:0] state, state_nxt;
    logic [3:0] op;
    logic [2:0] f_ra, f_rb, f_rc;
    logic       lmsm_start;
    logic [2:0] ls_index, ls_off;
    logic       ls_bit_set, ls_xfer, ls_done;

    assign op   = ir[15:12];
    assign f_ra = ir[11:9];
    assign f_rb = ir[8:6];
    assign f_rc = ir[5:3];

    assign lmsm_start = (state == S_DECODE) && ((op == OP_LM) || (op == OP_SM));

    mc_lmsm_seq u_lmsm_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (lmsm_start),
        .active    (state == S_LMSM),
        .mask      (ir[7:0]),
        .mem_ready (mem_ready),
        .index     (ls_index),
        .lmsm_off  (ls_off),
        .bit_set   (ls_bit_set),
        .xfer      (ls_xfer),
        .done      (ls_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_INC;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        addr_src  = AD_PC;
        lmsm_off  = ls_off;
        ra1       = f_ra;
        ra2       = f_rb;
        wa3       = '0;
        reg_we    = 1'b0;
        wd_src    = WD_ALU;
        alu_f     = ALU_ADD;
        alu_b_src = BS_RB;
        busy      = (state != S_FETCH);

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LHI:         state_nxt = S_ALUWB;
                    OP_JAL, OP_JLR: state_nxt = S_BRANCH;
                    OP_LM, OP_SM:   state_nxt = S_LMSM;
                    default:        state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_f     = alu_f_for(op);
                alu_b_src = b_src_for(op);
                case (op)
                    OP_ADD, OP_ADI, OP_NDU: state_nxt = S_ALUWB;
                    OP_LW:                  state_nxt = S_MEMRD;
                    OP_SW:                  state_nxt = S_MEMWR;
                    OP_BEQ:                 state_nxt = S_BRANCH;
                    default:                state_nxt = S_FETCH;
                endcase
            end
            S_ALUWB: begin
                reg_we    = 1'b1;
                alu_f     = alu_f_for(op);
                alu_b_src = b_src_for(op);
                wd_src    = (op == OP_LHI) ? WD_LHI : WD_ALU;
                wa3       = (op == OP_ADI) ? f_rb : ((op == OP_LHI) ? f_ra : f_rc);
                state_nxt = S_FETCH;
            end
            // Address ALU settings stay applied so the address is stable while waiting.
            S_MEMRD: begin
                mem_req   = 1'b1;
                addr_src  = AD_ALU;
                alu_f     = ALU_ADDNF;
                alu_b_src = BS_IMM6;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                addr_src  = AD_ALU;
                alu_f     = ALU_ADDNF;
                alu_b_src = BS_IMM6;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_MEMWB: begin
                reg_we    = 1'b1;
                wd_src    = WD_MEM;
                wa3       = f_ra;
                alu_f     = ALU_PASSB;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                if (op == OP_BEQ) begin
                    alu_f  = ALU_CMP;
                    pc_src = PC_IMM6;
                    pc_we  = alu_eq;
                end else begin
                    reg_we = 1'b1;
                    wa3    = f_ra;
                    wd_src = WD_PC1;
                    pc_we  = 1'b1;
                    pc_src = (op == OP_JAL) ? PC_IMM9 : PC_RB;
                end
                state_nxt = S_FETCH;
            end
            S_LMSM: begin
                addr_src = AD_LMSM;
                mem_req  = ls_bit_set;
                if (op == OP_SM) begin
                    mem_wr = ls_bit_set;
                    ra2    = ls_index;
                end else begin
                    reg_we = ls_xfer;
                    wd_src = WD_MEM;
                    wa3    = ls_index;
                    alu_f  = ALU_ADDNF;
                end
                if (ls_done) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Outputs are forced idle for the whole reset window, aborting any access.
        if (!rst_n) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = '0;
            mem_req   = 1'b0;
            mem_wr    = 1'b0;
            addr_src  = '0;
            lmsm_off  = '0;
            ra1       = '0;
            ra2       = '0;
            wa3       = '0;
            reg_we    = 1'b0;
            wd_src    = '0;
            alu_f     = '0;
            alu_b_src = '0;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction transaction model
// (memory accesses, register writes, PC loads, cycle count) vs observed.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic        alu_eq = 1'b0;
    logic        ir_we, pc_we, mem_req, mem_wr, reg_we, busy;
    logic [1:0]  pc_src, addr_src, wd_src, alu_b_src;
    logic [2:0]  lmsm_off, ra1, ra2, wa3, alu_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .mem_ready (mem_ready),
        .alu_eq    (alu_eq),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .addr_src  (addr_src),
        .lmsm_off  (lmsm_off),
        .ra1       (ra1),
        .ra2       (ra2),
        .wa3       (wa3),
        .reg_we    (reg_we),
        .wd_src    (wd_src),
        .alu_f     (alu_f),
        .alu_b_src (alu_b_src),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_ev(input logic wr, input logic [1:0] as,
                                           input logic [2:0] off, input logic [2:0] rd,
                                           input logic [2:0] f);
        return {4'b0, wr, as, off, rd, f};
    endfunction

    function automatic logic [15:0] wr_ev(input logic [2:0] a, input logic [1:0] src,
                                          input logic [2:0] f);
        return {8'b0, a, src, f};
    endfunction

    task automatic cmp_q(input string tag, input logic [15:0] got[$], input logic [15:0] exp[$]);
        chk({tag, "_count"}, 16'(got.size()), 16'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    // Called at a falling edge with the DUT in FETCH; returns at the next FETCH.
    task automatic run_instr(input logic [15:0] iv, input logic eqv);
        int w[$];
        logic [15:0] exp_mem[$], got_mem[$], exp_wr[$], got_wr[$], exp_pc[$], got_pc[$];
        logic [3:0] op;
        logic [2:0] fa, fb, fc;
        int exp_cyc, cyc, na, k, wi, cnt, irw, both;
        logic seen_busy, done, pend, p_wr;
        logic [1:0] p_as;
        logic [2:0] p_off;
        string tag;

        op = iv[15:12]; fa = iv[11:9]; fb = iv[8:6]; fc = iv[5:3];
        tag = $sformatf("ir%h", iv);
        for (int i = 0; i < 9; i++) w.push_back(int'($urandom_range(0, 3)));

        // Expected transactions, derived from the instruction semantics.
        exp_mem.push_back(mem_ev(1'b0, 2'b00, 3'd0, 3'd0, 3'd0));
        exp_pc.push_back(16'd0);
        exp_cyc = w[0] + 1 + 1;
        na = 1;
        case (op)
            4'b0000: begin exp_wr.push_back(wr_ev(fc, 2'b00, 3'b000)); exp_cyc += 2; end
            4'b0001: begin exp_wr.push_back(wr_ev(fb, 2'b00, 3'b000)); exp_cyc += 2; end
            4'b0010: begin exp_wr.push_back(wr_ev(fc, 2'b00, 3'b001)); exp_cyc += 2; end
            4'b0011: begin exp_wr.push_back(wr_ev(fa, 2'b10, 3'b100)); exp_cyc += 1; end
            4'b0100: begin
                exp_mem.push_back(mem_ev(1'b0, 2'b01, 3'd0, 3'd0, 3'b100));
                exp_wr.push_back(wr_ev(fa, 2'b01, 3'b010));
                exp_cyc += 1 + w[1] + 1 + 1;
            end
            4'b0101: begin
                exp_mem.push_back(mem_ev(1'b1, 2'b01, 3'd0, 3'd0, 3'b100));
                exp_cyc += 1 + w[1] + 1;
            end
            4'b0110, 4'b0111: begin
                k = 0;
                for (int i = 1; i < 8; i++) begin
                    if (iv[i]) begin
                        exp_mem.push_back(mem_ev(op[0], 2'b10, 3'(k), op[0] ? 3'(i) : 3'd0, 3'd0));
                        if (!op[0]) exp_wr.push_back(wr_ev(3'(i), 2'b01, 3'b100));
                        exp_cyc += w[na] + 1;
                        na++;
                        k++;
                    end else begin
                        exp_cyc += 1;
                    end
                end
            end
            4'b1000, 4'b1001: begin
                exp_wr.push_back(wr_ev(fa, 2'b11, 3'd0));
                exp_pc.push_back(op[0] ? 16'd3 : 16'd2);
                exp_cyc += 1;
            end
            4'b1100: begin
                if (eqv) exp_pc.push_back(16'd1);
                exp_cyc += 2;
            end
            default: exp_cyc += 1;
        endcase

        ir = iv;
        alu_eq = eqv;
        cyc = 0; wi = 0; cnt = 0; irw = 0; both = 0;
        seen_busy = 1'b0; done = 1'b0; pend = 1'b0;
        p_wr = 1'b0; p_as = '0; p_off = '0;
        while (cyc < 80) begin
            if (seen_busy && !busy) begin
                done = 1'b1;
                break;
            end
            if (mem_req) mem_ready = (wi < 9) ? (cnt >= w[wi]) : 1'b1;
            else         mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (pend) begin
                chk({tag, "_hold_req"}, 16'(mem_req), 16'd1);
                chk({tag, "_hold_wr"}, 16'(mem_wr), 16'(p_wr));
                chk({tag, "_hold_addr"}, 16'(addr_src), 16'(p_as));
                chk({tag, "_hold_off"}, 16'(lmsm_off), 16'(p_off));
            end
            pend = mem_req && !mem_ready;
            p_wr = mem_wr; p_as = addr_src; p_off = lmsm_off;
            if (mem_req && mem_ready) begin
                got_mem.push_back(mem_ev(mem_wr, addr_src,
                    (addr_src == 2'b10) ? lmsm_off : 3'd0,
                    (addr_src == 2'b10 && mem_wr) ? ra2 : 3'd0,
                    (addr_src == 2'b01) ? alu_f : 3'd0));
                wi++;
                cnt = 0;
            end else if (mem_req) begin
                cnt++;
            end
            if (reg_we) got_wr.push_back(wr_ev(wa3, wd_src, (wd_src == 2'b11) ? 3'd0 : alu_f));
            if (pc_we) got_pc.push_back(16'(pc_src));
            if (ir_we) irw++;
            if (reg_we && pc_we) both++;
            seen_busy |= busy;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_finished"}, 16'(done), 16'd1);
        chk({tag, "_cycles"}, 16'(cyc), 16'(exp_cyc));
        chk({tag, "_ir_we"}, 16'(irw), 16'd1);
        chk({tag, "_link_and_pc"}, 16'(both), (op == 4'b1000 || op == 4'b1001) ? 16'd1 : 16'd0);
        cmp_q({tag, "_mem"}, got_mem, exp_mem);
        cmp_q({tag, "_regwr"}, got_wr, exp_wr);
        cmp_q({tag, "_pcld"}, got_pc, exp_pc);
    endtask

    logic [3:0] op_tab [12];

    initial begin
        op_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hA};

        #1;
        chk("rst_ir_we", 16'(ir_we), 16'd0);
        chk("rst_pc_we", 16'(pc_we), 16'd0);
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_wr", 16'(mem_wr), 16'd0);
        chk("rst_reg_we", 16'(reg_we), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_lmsm_off", 16'(lmsm_off), 16'd0);
        chk("rst_others", {pc_src, addr_src, ra1, ra2, wa3, wd_src}, 16'd0);
        chk("rst_alu", {11'd0, alu_f, alu_b_src}, 16'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_req", 16'(mem_req), 16'd1);
        chk("fetch_addr", 16'(addr_src), 16'd0);

        run_instr(16'h0298, 1'b0);   // ADD R1,R2,R3
        run_instr(16'h4883, 1'b0);   // LW R4,R2,+3
        run_instr(16'hC283, 1'b0);   // BEQ not taken
        run_instr(16'hC283, 1'b1);   // BEQ taken
        run_instr(16'h608A, 1'b0);   // LM mask R1,R3,R7 (+bit0 ignored below)
        run_instr(16'h608B, 1'b0);
        run_instr(16'h7000, 1'b0);   // SM empty mask
        run_instr(16'h7001, 1'b0);
        run_instr(16'h8A05, 1'b0);   // JAL R5
        run_instr(16'h9A80, 1'b0);   // JLR
        run_instr(16'h3E55, 1'b0);   // LHI
        run_instr(16'hA123, 1'b0);   // NOP opcode
        run_instr(16'h7EFF, 1'b0);   // SM full mask

        for (int n = 0; n < 40; n++)
            run_instr({op_tab[$urandom_range(0, 11)], 12'($urandom)}, 1'($urandom_range(0, 1)));

        // Abort a store mid-request.
        ir = 16'h5283;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("memwr_req", 16'(mem_req), 16'd1);
        chk("memwr_wr", 16'(mem_wr), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_req", 16'(mem_req), 16'd0);
        chk("abort_wr", 16'(mem_wr), 16'd0);
        chk("abort_we", {13'd0, reg_we, pc_we, ir_we}, 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_busy", 16'(busy), 16'd0);
        chk("post_rst_req", 16'(mem_req), 16'd1);
        chk("post_rst_wr", 16'(mem_wr), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
